// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: major opcodes, the decoder's instruction classes,
// and the program-loader session states.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        CL_LOAD   = 3'd0,
        CL_STORE  = 3'd1,
        CL_R      = 3'd2,
        CL_I      = 3'd3,
        CL_LUI    = 3'd4,
        CL_BRANCH = 3'd5,
        CL_JAL    = 3'd6,
        CL_JALR   = 3'd7
    } instr_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the instruction word for a class
// and flags immediates that the target format cannot represent.
module instr_pack
    import riscv_pkg::*;
(
    input  instr_class_e       i_class,
    input  logic [2:0]         i_funct3,
    input  logic               i_funct7b5,
    input  logic [4:0]         i_rd,
    input  logic [4:0]         i_rs1,
    input  logic [4:0]         i_rs2,
    input  logic signed [31:0] i_imm,
    output logic [31:0]        o_word,
    output logic               o_illegal
);

    logic       w_fits12;
    logic       w_fits13;
    logic       w_fits21;
    logic       w_is_shift;
    logic [6:0] w_f7;

    // Sign-extension tests: the value fits when every bit above the field's MSB copies it.
    assign w_fits12   = (i_imm[31:11] == {21{i_imm[11]}});
    assign w_fits13   = (i_imm[31:12] == {20{i_imm[12]}});
    assign w_fits21   = (i_imm[31:20] == {12{i_imm[20]}});
    assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_f7       = {1'b0, i_funct7b5, 5'b00000};

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        unique case (i_class)
            CL_LOAD: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
                o_illegal = !w_fits12;
            end
            CL_STORE: begin
                o_word    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
                o_illegal = !w_fits12;
            end
            CL_R: begin
                o_word    = {w_f7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            end
            CL_I: begin
                if (w_is_shift) begin
                    o_word    = {w_f7, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_I};
                    o_illegal = (i_imm[31:5] != 27'd0);
                end else begin
                    o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                    o_illegal = !w_fits12;
                end
            end
            CL_LUI: begin
                o_word    = {i_imm[31:12], i_rd, OP_LUI};
                o_illegal = (i_imm[11:0] != 12'd0);
            end
            CL_BRANCH: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_BRANCH};
                o_illegal = !w_fits13 || i_imm[0];
            end
            CL_JAL: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                o_illegal = !w_fits21 || i_imm[0];
            end
            CL_JALR: begin
                o_word    = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
                o_illegal = !w_fits12;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded field bundles over valid/ready and writes the
// encoded RV32I words to consecutive instruction-memory addresses.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    enc_state_e        r_state;
    enc_state_e        w_next_state;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic              r_last_acc;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_fire;
    logic              w_start_ok;

    instr_pack u_pack (
        .i_class    (instr_class_e'(in_class)),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .i_rd       (in_rd),
        .i_rs1      (in_rs1),
        .i_rs2      (in_rs2),
        .i_imm      (in_imm),
        .o_word     (w_word),
        .o_illegal  (w_illegal)
    );

    assign in_ready   = (r_state == RUN) && !r_last_acc && (r_count < LP_DEPTH);
    assign w_fire     = in_valid && in_ready;
    assign w_start_ok = start && (r_state != RUN);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // An error leaves RUN at once; the last word and the depth limit leave after their write cycle.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: if (start) w_next_state = RUN;
            RUN: begin
                if (w_fire && w_illegal)                      w_next_state = DONE;
                else if (r_last_acc || (r_count == LP_DEPTH)) w_next_state = DONE;
            end
            DONE: if (start) w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_count     <= '0;
            r_next_addr <= '0;
            r_last_acc  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we <= w_fire && !w_illegal;
            if (w_start_ok) begin
                r_next_addr <= base_addr;
                r_count     <= '0;
                r_err       <= 1'b0;
                r_last_acc  <= 1'b0;
            end else if (w_fire) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_addr      <= r_next_addr;
                    r_wdata     <= w_word;
                    r_next_addr <= r_next_addr + 1'b1;
                    r_count     <= r_count + 1'b1;
                    r_last_acc  <= in_last;
                end
            end
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign word_count = r_count;
    assign done       = (r_state == DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table-driven encodings plus hand-written
// sequences for session control, errors, address wrap, depth limit and reset.
module tb_instr_encoder;

    localparam logic [2:0] C_LOAD = 3'd0, C_STORE = 3'd1, C_R = 3'd2, C_I = 3'd3,
                           C_LUI = 3'd4, C_BR = 3'd5, C_JAL = 3'd6, C_JALR = 3'd7;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_funct7b5, in_last;
    logic [8:0]  base_addr, mem_addr;
    logic [2:0]  in_class, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, mem_wdata;
    logic        mem_we, done, err;
    logic [9:0]  word_count;

    int n_chk = 0;
    int n_err = 0;

    vec_t tbl[14];
    vec_t bad[12];

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .done(done), .err(err)
    );

    function automatic vec_t mk(logic [2:0] c, logic [2:0] f3, logic f7, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm,
                                logic last, logic [31:0] exp);
        vec_t v;
        v.cls = c; v.f3 = f3; v.f7b5 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.last = last; v.exp = exp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1; in_class = v.cls; in_funct3 = v.f3; in_funct7b5 = v.f7b5;
        in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm; in_last = v.last;
    endtask

    task automatic do_start(input logic [8:0] base);
        start = 1'b1; base_addr = base;
        tick();
        start = 1'b0;
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        chk("start_wc", 32'(word_count), 32'd0);
    endtask

    // Streams tbl[first..last_i] back to back and checks each write one cycle after acceptance.
    task automatic run_stream(input int first, input int last_i, input logic [8:0] base);
        logic [8:0] a;
        for (int i = first; i <= last_i; i++) begin
            drive(tbl[i]);
            chk($sformatf("ready[%0d]", i), 32'(in_ready), 32'd1);
            tick();
            a = base + 9'(i - first);
            chk($sformatf("we[%0d]", i), 32'(mem_we), 32'd1);
            chk($sformatf("addr[%0d]", i), 32'(mem_addr), 32'(a));
            chk($sformatf("word[%0d]", i), mem_wdata, tbl[i].exp);
            chk($sformatf("wc[%0d]", i), 32'(word_count), 32'(i - first + 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic end_session(input int exp_wc);
        chk("end_ready", 32'(in_ready), 32'd0);
        tick();
        chk("end_done", 32'(done), 32'd1);
        chk("end_we", 32'(mem_we), 32'd0);
        chk("end_wc", 32'(word_count), 32'(exp_wc));
        chk("end_err", 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        tbl[0]  = mk(C_I,     3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd5,          1'b0, 32'h00500093);
        tbl[1]  = mk(C_R,     3'd0, 1'b0, 5'd3,  5'd1,  5'd2,  32'd0,          1'b0, 32'h002081B3);
        tbl[2]  = mk(C_STORE, 3'd2, 1'b0, 5'd31, 5'd1,  5'd2,  32'd8,          1'b0, 32'h0020A423);
        tbl[3]  = mk(C_LOAD,  3'd2, 1'b0, 5'd6,  5'd7,  5'd31, 32'hFFFF_FFFF,  1'b0, 32'hFFF3A303);
        tbl[4]  = mk(C_I,     3'd5, 1'b1, 5'd10, 5'd11, 5'd0,  32'd3,          1'b0, 32'h4035D513);
        tbl[5]  = mk(C_R,     3'd0, 1'b1, 5'd3,  5'd1,  5'd2,  32'd0,          1'b0, 32'h402081B3);
        tbl[6]  = mk(C_JALR,  3'd0, 1'b0, 5'd0,  5'd1,  5'd0,  32'd0,          1'b0, 32'h00008067);
        tbl[7]  = mk(C_I,     3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd2047,       1'b0, 32'h7FF00093);
        tbl[8]  = mk(C_I,     3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFF_F800,  1'b1, 32'h80000093);
        tbl[9]  = mk(C_BR,    3'd0, 1'b0, 5'd7,  5'd1,  5'd2,  32'hFFFF_FFFC,  1'b0, 32'hFE208EE3);
        tbl[10] = mk(C_JAL,   3'd0, 1'b0, 5'd1,  5'd0,  5'd0,  32'd8,          1'b1, 32'h008000EF);
        tbl[11] = mk(C_LUI,   3'd0, 1'b0, 5'd5,  5'd0,  5'd0,  32'h1234_5000,  1'b0, 32'h123452B7);
        tbl[12] = mk(C_BR,    3'd1, 1'b0, 5'd0,  5'd3,  5'd4,  32'd4094,       1'b0, 32'h7E419FE3);
        tbl[13] = mk(C_JAL,   3'd0, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFF0_0000,  1'b1, 32'h8000006F);

        bad[0]  = mk(C_I,     3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048,         1'b0, 32'd0);
        bad[1]  = mk(C_LOAD,  3'd2, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F7FF,    1'b0, 32'd0);
        bad[2]  = mk(C_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd2048,         1'b0, 32'd0);
        bad[3]  = mk(C_JALR,  3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F7FF,    1'b0, 32'd0);
        bad[4]  = mk(C_I,     3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,           1'b0, 32'd0);
        bad[5]  = mk(C_I,     3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF,    1'b0, 32'd0);
        bad[6]  = mk(C_BR,    3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,            1'b0, 32'd0);
        bad[7]  = mk(C_BR,    3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4096,         1'b0, 32'd0);
        bad[8]  = mk(C_BR,    3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_EFFE,    1'b0, 32'd0);
        bad[9]  = mk(C_JAL,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1,            1'b0, 32'd0);
        bad[10] = mk(C_JAL,   3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000,    1'b0, 32'd0);
        bad[11] = mk(C_LUI,   3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001,    1'b1, 32'd0);

        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        drive(tbl[0]); in_valid = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Bundles offered while idle are ignored.
        in_valid = 1'b1;
        tick(); tick();
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        do_start(9'h010);
        run_stream(0, 8, 9'h010);
        end_session(9);

        // Restart from DONE; start held high during RUN must not disturb the session.
        do_start(9'h020);
        start = 1'b1; base_addr = 9'h100;
        run_stream(9, 10, 9'h020);
        start = 1'b0;
        end_session(2);

        do_start(9'h030);
        run_stream(11, 11, 9'h030);
        drive(bad[11]);
        tick();
        chk("lui_bad_we", 32'(mem_we), 32'd0);
        chk("lui_bad_err", 32'(err), 32'd1);
        chk("lui_bad_done", 32'(done), 32'd1);
        chk("lui_bad_ready", 32'(in_ready), 32'd0);
        chk("lui_bad_wc", 32'(word_count), 32'd1);
        in_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_start(9'h050);
            drive(bad[i]);
            tick();
            chk($sformatf("bad_we[%0d]", i), 32'(mem_we), 32'd0);
            chk($sformatf("bad_err[%0d]", i), 32'(err), 32'd1);
            chk($sformatf("bad_done[%0d]", i), 32'(done), 32'd1);
            chk($sformatf("bad_ready[%0d]", i), 32'(in_ready), 32'd0);
            tick();
            chk($sformatf("bad_hold_we[%0d]", i), 32'(mem_we), 32'd0);
            chk($sformatf("bad_hold_wc[%0d]", i), 32'(word_count), 32'd0);
            chk($sformatf("bad_hold_err[%0d]", i), 32'(err), 32'd1);
            in_valid = 1'b0;
        end

        do_start(9'h1FF);
        run_stream(12, 13, 9'h1FF);
        end_session(2);

        // Fill to the depth limit without in_last.
        do_start(9'h000);
        for (int i = 0; i < 512; i++) begin
            v = mk(C_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0,
                   {20'(i), 5'd0, 3'd0, 5'd1, 7'h13});
            drive(v);
            chk($sformatf("dep_ready[%0d]", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("dep_we[%0d]", i), 32'(mem_we), 32'd1);
            chk($sformatf("dep_addr[%0d]", i), 32'(mem_addr), 32'(i));
            chk($sformatf("dep_word[%0d]", i), mem_wdata, v.exp);
        end
        chk("dep_ready_low", 32'(in_ready), 32'd0);
        chk("dep_wc", 32'(word_count), 32'd512);
        tick();
        chk("dep_done", 32'(done), 32'd1);
        chk("dep_no_extra_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;

        // Reset in the middle of a stream.
        do_start(9'h040);
        drive(tbl[0]);
        tick();
        chk("mid_we", 32'(mem_we), 32'd1);
        drive(tbl[1]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_wc", 32'(word_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
